// File: rtl/guesser_pkg.sv
// Shared types and constants for the BCD auto-guesser: FSM state encoding,
// datapath widths and the double-dabble digit adjust.
package guesser_pkg;

   localparam int BIN_W    = 14;
   localparam int BCD_W    = 16;
   localparam int N_DIGITS = 4;
   localparam int BCD_MAX  = 9999;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_CONV,
      ST_SUBMIT,
      ST_WAIT,
      ST_EVAL,
      ST_DONE,
      ST_ERR
   } state_e;

   // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int d = 0; d < N_DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5) res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble converter: one shift per cycle, done pulses during
// the final shift cycle, 14 cycles after start, with the finished BCD on bcd.
module bin2bcd_iter
   import guesser_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   logic [BIN_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [BCD_W-1:0] bcd_step;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      bcd_step = BCD_W'({dabble_adjust(bcd_q), bin_q[BIN_W-1]});
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         bin_d  = bin;
         bcd_d  = '0;
         cnt_d  = 4'(BIN_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         bin_d = {bin_q[BIN_W-2:0], 1'b0};
         bcd_d = bcd_step;
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) busy_d = 1'b0;
      end
   end

   // The last shift is presented combinationally so the caller can register it on done.
   assign done = busy_q && (cnt_q == 4'd1);
   assign bcd  = bcd_step;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/bcd_auto_guesser.sv
// Binary-search player for the BCD comparator game. Optional guess limit is
// enabled by defining GUESS_LIMIT_EN (MAX_TRIES is ignored otherwise).
module bcd_auto_guesser
   import guesser_pkg::*;
#(
   parameter int unsigned LO_INIT   = 0,
   parameter int unsigned HI_INIT   = 9999,
   parameter int unsigned FB_WAIT   = 2,
   parameter int unsigned MAX_TRIES = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             fb_eq,
   input  logic             fb_gt,
   input  logic             fb_sm,
   output logic [BCD_W-1:0] guess,
   output logic             submit,
   output logic             busy,
   output logic             found,
   output logic             err,
   output logic [3:0]       attempts
);

`ifdef GUESS_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   state_e           state_q, state_d;
   logic [BIN_W-1:0] lo_q, lo_d, hi_q, hi_d, mid_q, mid_d, mid_calc;
   logic [BCD_W-1:0] guess_q, guess_d;
   logic [3:0]       attempts_q, attempts_d;
   logic [7:0]       wait_q, wait_d;
   logic [2:0]       flags;
   logic             limit_hit;
   logic             conv_done;
   logic [BCD_W-1:0] conv_bcd;

   // 15-bit sum so lo+hi near 9999 does not overflow before halving.
   assign mid_calc  = BIN_W'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
   assign flags     = {fb_eq, fb_gt, fb_sm};
   assign limit_hit = LIMIT_EN && (32'(attempts_q) >= MAX_TRIES);

   bin2bcd_iter u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (state_q == ST_CALC),
      .bin   (mid_calc),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      mid_d      = mid_q;
      guess_d    = guess_q;
      attempts_d = attempts_q;
      wait_d     = wait_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               lo_d       = BIN_W'(LO_INIT);
               hi_d       = BIN_W'(HI_INIT);
               attempts_d = '0;
               state_d    = ST_CALC;
            end
         end
         ST_CALC: begin
            mid_d   = mid_calc;
            state_d = ST_CONV;
         end
         ST_CONV: begin
            if (conv_done) begin
               guess_d = conv_bcd;
               state_d = ST_SUBMIT;
            end
         end
         ST_SUBMIT: begin
            if (attempts_q != 4'hf) attempts_d = attempts_q + 4'd1;
            wait_d  = 8'(FB_WAIT - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_q == 8'd0) state_d = ST_EVAL;
            else                wait_d  = wait_q - 8'd1;
         end
         ST_EVAL: begin
            case (flags)
               3'b100: state_d = ST_DONE;
               3'b010: begin
                  if (mid_q == lo_q) state_d = ST_ERR;
                  else begin
                     hi_d    = mid_q - 14'd1;
                     state_d = ST_CALC;
                  end
               end
               3'b001: begin
                  if (mid_q == hi_q) state_d = ST_ERR;
                  else begin
                     lo_d    = mid_q + 14'd1;
                     state_d = ST_CALC;
                  end
               end
               default: state_d = ST_ERR;
            endcase
            if (flags != 3'b100 && limit_hit) state_d = ST_ERR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lo_q       <= '0;
         hi_q       <= '0;
         mid_q      <= '0;
         guess_q    <= '0;
         attempts_q <= '0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         mid_q      <= mid_d;
         guess_q    <= guess_d;
         attempts_q <= attempts_d;
         wait_q     <= wait_d;
      end
   end

   assign guess    = guess_q;
   assign attempts = attempts_q;
   assign submit   = (state_q == ST_SUBMIT);
   assign found    = (state_q == ST_DONE);
   assign err      = (state_q == ST_ERR);
   assign busy     = (state_q == ST_CALC) || (state_q == ST_CONV) || (state_q == ST_SUBMIT) ||
                     (state_q == ST_WAIT) || (state_q == ST_EVAL);

endmodule

// File: tb/tb_bcd_auto_guesser.sv
// Scoreboard bench for bcd_auto_guesser: a reference binary search queues the
// expected guesses, each submit pops one, and a comparator model answers.
module tb_bcd_auto_guesser;

   logic        clk = 1'b0;
   logic        rst_n, start, fb_eq, fb_gt, fb_sm;
   logic [15:0] guess;
   logic        submit, busy, found, err;
   logic [3:0]  attempts;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   bcd_auto_guesser dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .fb_eq(fb_eq), .fb_gt(fb_gt), .fb_sm(fb_sm),
      .guess(guess), .submit(submit), .busy(busy),
      .found(found), .err(err), .attempts(attempts)
   );

`ifdef GUESS_LIMIT_EN
   logic        lim_start = 1'b0;
   logic [15:0] lim_guess;
   logic        lim_submit, lim_busy, lim_found, lim_err;
   logic [3:0]  lim_attempts;

   bcd_auto_guesser #(.MAX_TRIES(3)) dut_lim (
      .clk(clk), .rst_n(rst_n), .start(lim_start),
      .fb_eq(1'b0), .fb_gt(1'b0), .fb_sm(1'b1),
      .guess(lim_guess), .submit(lim_submit), .busy(lim_busy),
      .found(lim_found), .err(lim_err), .attempts(lim_attempts)
   );
`endif

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int from_bcd(input logic [15:0] b);
      return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   task automatic clear_fb();
      fb_eq = 1'b0;
      fb_gt = 1'b0;
      fb_sm = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      clear_fb();
      repeat (3) @(negedge clk);
      vectors++;
      if ({guess, submit, busy, found, err, attempts} !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, expected 000000",
                  {guess, submit, busy, found, err, attempts});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Secret 4999: the very first guess hits, so the cycle timing is fully pinned down.
   task automatic test_first_guess();
      int n;
      clear_fb();
      exp_q.push_back(16'h4999);
      start = 1'b1;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         if (submit) break;
      end
      vectors++;
      if (n !== 16) begin
         miscompares++;
         $display("FAIL first_submit_cycle: got %0d, expected 16", n);
      end
      vectors++;
      if (guess !== exp_q.pop_front()) begin
         miscompares++;
         $display("FAIL first_guess: got %h, expected 4999", guess);
      end
      fb_eq = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({found, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL eval_cycle_found_busy: got %b, expected 01", {found, busy});
      end
      @(negedge clk);
      vectors++;
      if ({found, busy, err, attempts, guess} !== {3'b100, 4'd1, 16'h4999}) begin
         miscompares++;
         $display("FAIL done_state: found/busy/err=%b%b%b attempts=%0d guess=%h, expected 100 1 4999",
                  found, busy, err, attempts, guess);
      end
   endtask

   task automatic run_game(input int secret, output int n_guess);
      int lo, hi, mid, g, cyc;
      lo = 0; hi = 9999; n_guess = 0;
      for (int k = 0; k < 20; k++) begin
         mid = (lo + hi) / 2;
         exp_q.push_back(to_bcd(mid));
         n_guess++;
         if (mid == secret) break;
         if (mid > secret) hi = mid - 1;
         else              lo = mid + 1;
      end
      clear_fb();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (cyc = 0; cyc < 400 && !(found || err); cyc++) begin
         if (submit) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL extra_submit: got guess %h, expected no submit", guess);
            end else if (guess !== exp_q[0]) begin
               miscompares++;
               $display("FAIL guess_seq secret=%0d: got %h, expected %h", secret, guess, exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            g = from_bcd(guess);
            fb_eq = (g == secret);
            fb_gt = (g > secret);
            fb_sm = (g < secret);
         end
         @(negedge clk);
      end
      vectors++;
      if ({found, err, busy, guess} !== {3'b100, to_bcd(secret)}) begin
         miscompares++;
         $display("FAIL game_end secret=%0d: found/err/busy=%b%b%b guess=%h, expected 100 %h",
                  secret, found, err, busy, guess, to_bcd(secret));
      end
      vectors++;
      if (attempts !== 4'(n_guess) || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL attempts secret=%0d: got %0d (left %0d), expected %0d (left 0)",
                  secret, attempts, exp_q.size(), n_guess);
      end
      exp_q.delete();
   endtask

   task automatic test_edge_secrets();
      int n;
      run_game(9999, n);
      vectors++;
      if (attempts > 4'd14) begin
         miscompares++;
         $display("FAIL max_secret_attempts: got %0d, expected <= 14", attempts);
      end
      run_game(0, n);
      for (int i = 0; i < 3; i++) run_game(int'($urandom_range(0, 9999)), n);
   endtask

   // A new game is launched straight out of DONE with no idle gap.
   task automatic test_back_to_back();
      int n;
      run_game(1234, n);
      run_game(5000, n);
   endtask

   task automatic test_contradiction();
      int n, subs;
      clear_fb();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (n = 0; n < 40 && !submit; n++) @(negedge clk);
      fb_gt = 1'b1;
      fb_sm = 1'b1;
      for (n = 0; n < 30 && !err; n++) @(negedge clk);
      vectors++;
      if ({err, busy, found, attempts} !== {3'b100, 4'd1}) begin
         miscompares++;
         $display("FAIL contradiction: err/busy/found=%b%b%b attempts=%0d, expected 100 1",
                  err, busy, found, attempts);
      end
      subs = 0;
      repeat (60) begin
         @(negedge clk);
         if (submit) subs++;
      end
      vectors++;
      if (subs !== 0 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL err_sticky: got %0d submits err=%b, expected 0 submits err=1", subs, err);
      end
      clear_fb();
   endtask

   task automatic test_reset_mid();
      int n;
      clear_fb();
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if ({guess, submit, busy, found, err, attempts} !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_mid: got %h, expected 000000",
                  {guess, submit, busy, found, err, attempts});
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_game(4999, n);
   endtask

`ifdef GUESS_LIMIT_EN
   task automatic test_guess_limit();
      int n;
      lim_start = 1'b1;
      for (n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n == 1) lim_start = 1'b0;
         if (lim_err) break;
      end
      vectors++;
      if (n !== 58 || lim_attempts !== 4'd3 || lim_found !== 1'b0) begin
         miscompares++;
         $display("FAIL guess_limit: err at cycle %0d attempts=%0d found=%b, expected 58 3 0",
                  n, lim_attempts, lim_found);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_guess();
      test_edge_secrets();
      test_back_to_back();
      test_contradiction();
      test_reset_mid();
`ifdef GUESS_LIMIT_EN
      test_guess_limit();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bcd_auto_guesser.md
# bcd_auto_guesser

Automatic player for the guessing-number game. It drives the opposite end of the BCD comparator interface: it generates a 4-digit BCD guess and strobes `submit`, then reads back the `eq`/`gt`/`sm` verdict. It narrows the search by binary search until the verdict is equal. It sits in the demo/self-test path in place of the keypad guess-entry logic.

## Interface
- `LO_INIT`, default 0: initial lower bound, binary.
- `HI_INIT`, default 9999: initial upper bound, binary. Constraints: ≤ 9999 and ≥ `LO_INIT`.
- `FB_WAIT`, default 2: cycles after `submit` falls before the verdict is sampled. Must be ≥ 1.
- `MAX_TRIES`, default 14: guess limit. Used only with `GUESS_LIMIT_EN`.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: level or pulse. Begins a new game when the block is not busy.
- `fb_eq` in 1: comparator verdict, guess equals secret.
- `fb_gt` in 1: comparator verdict, guess greater than secret.
- `fb_sm` in 1: comparator verdict, guess smaller than secret.
- `guess` out 16: current guess, 4 BCD digits, [15:12] most significant.
- `submit` out 1: one-cycle high strobe. The comparator evaluates on its falling edge.
- `busy` out 1: game in progress.
- `found` out 1: an equal verdict was received. `guess` holds the secret.
- `err` out 1: contradictory verdict, empty search range, or limit exceeded.
- `attempts` out 4: number of submitted guesses, saturates at 15.

## Operation
- FSM states: IDLE, CALC, CONV, SUBMIT, WAIT, EVAL, DONE, ERR.
- IDLE/DONE/ERR + `start`=1:
  - lo←`LO_INIT`, hi←`HI_INIT`, attempts←0, found←0, err←0, busy←1.
  - Next state CALC.
- `start` is ignored in all other states.
- CALC:
  - mid = (lo+hi)>>1, computed with a 15-bit sum, result 14 bits.
  - Launch the binary-to-BCD conversion. Next state CONV.
- CONV: wait for converter `done`. `guess`←BCD(mid) on `done`. Next state SUBMIT.
- SUBMIT: `submit`=1 for exactly one cycle; attempts increments (saturating). Next state WAIT.
- WAIT: `submit`=0 and `guess` held for `FB_WAIT` cycles. Next state EVAL.
- EVAL samples the flags. Exactly one flag must be high, otherwise → ERR.
  - `fb_eq` → DONE: found=1, busy=0, `guess` held.
  - `fb_gt`: if mid==lo → ERR; else hi←mid−1, → CALC.
  - `fb_sm`: if mid==hi → ERR; else lo←mid+1, → CALC.
- ERR: err=1, busy=0, `guess` held. Left only by `start` or reset.
- `guess` changes only on conversion `done`. It is stable across every `submit` edge and throughout WAIT.

## Timing
- Reset values: guess=16'h0000, submit=0, busy=0, found=0, err=0, attempts=0. State IDLE, lo=hi=0.
- `start` sampled high in cycle 0:
  - CALC in cycle 1.
  - CONV in cycles 2–15: 14 converter iterations, result registered at the end of cycle 15.
  - `submit` high in cycle 16.
  - WAIT in cycles 17..16+`FB_WAIT`.
  - EVAL in cycle 17+`FB_WAIT`.
- Per-guess period: 17+`FB_WAIT` cycles (19 at default).
- found/err assert in the cycle after EVAL.
- Reset mid-operation: all outputs return to reset values on the next edge.
  - If `submit` was high at that point, its falling edge causes one spurious comparator evaluation. This is permitted, because the verdict is discarded.
- The flags are only ever sampled in EVAL. Changes during WAIT are ignored.

## Configuration
- `GUESS_LIMIT_EN` defined:
  - In EVAL, a non-eq verdict with attempts ≥ `MAX_TRIES` → ERR.
- Not defined:
  - No limit. Termination is guaranteed by range collapse (≤14 guesses over 0–9999).
  - `MAX_TRIES` is unused.

## Structure
- Package `guesser_pkg` holds:
  - State enum.
  - `BIN_W`=14, `BCD_W`=16, `N_DIGITS`=4.
  - `BCD_MAX`=9999.
- Sub-module `bin2bcd_iter`: iterative double-dabble converter, 14-bit binary to 16-bit BCD.
  - `start`/`done` handshake; one shift per cycle.
  - `done` pulses one cycle, 14 cycles after `start`.
  - Synchronous active-low reset.

## Test plan
- Secret 4999; `start` → `submit` at cycle 16 with guess=16'h4999; eq at EVAL → found=1, attempts=1, busy=0 at cycle 20.
- Secret 9999, behavioural comparator → only sm verdicts; final guess 16'h9999, found=1, attempts ≤14.
- Secret 0000 → only gt verdicts; final guess 16'h0000, found=1, no err.
- Responder drives fb_gt=fb_sm=1 at the first EVAL → err=1, busy=0, no further `submit`.
- `rst_n`=0 in cycle 8 (during CONV) → all outputs zero next cycle; a later `start` produces first guess 16'h4999 again.
- `GUESS_LIMIT_EN`, `MAX_TRIES`=3, responder always sm → err=1 after the third EVAL, attempts=3.
